// File: rtl/bus_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package bus_pkg;

  // Number of RAM words when the instantiating design does not override it.
  localparam int unsigned DEPTH_DEFAULT = 100_000;

  // Arbiter ownership state: IDLE, or requester n holds a lock.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Index of a requester: 0 = CPU, 1 = debug panel.
  typedef logic req_idx_t;

  // One-hot select vector for a requester index.
  function automatic logic [1:0] idx_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Two-input round-robin picker: on a tie the requester not named by the
// pointer (the last winner) is chosen.
module rr_pick
  import bus_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_idx_t   ptr_i,
  output logic [1:0] gnt_o
);

  // One-hot grant from the request pair and the last-winner pointer.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = idx_onehot(~ptr_i);
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a single-port RAM between the CPU (m0) and the debug panel (m1).
// Grants are combinational, read data returns one cycle later and is routed
// back by a registered requester index.
module ram_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_lock,
  input  logic             m0_enw,
  input  logic [WIDTH-1:0] m0_address,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [WIDTH-1:0] m0_rdata,
  output logic             m0_err,
  input  logic             m1_req,
  input  logic             m1_lock,
  input  logic             m1_enw,
  input  logic [WIDTH-1:0] m1_address,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] m1_rdata,
  output logic             m1_err,
  output logic             ram_enw,
  output logic [WIDTH-1:0] ram_address,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

  arb_state_e       state_q, state_d;
  req_idx_t         ptr_q, ptr_d;
  logic [1:0]       pick_s, gnt_s, rsp_oh_s;
  logic             any_gnt_s, sel_enw_s, sel_oor_s;
  req_idx_t         sel_s;
  logic [WIDTH-1:0] sel_addr_s, sel_wdata_s;
  logic             rsp_rd_q, rsp_rd_d, rsp_oor_q, rsp_oor_d;
  req_idx_t         rsp_idx_q, rsp_idx_d;

  rr_pick u_rr_pick (
    .req_i (({m1_req, m0_req})),
    .ptr_i (ptr_q),
    .gnt_o (pick_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a grant decides by its lock bit; an owner that goes quiet
  // without lock releases the bus.
  always_comb begin
    state_d = state_q;
    if (gnt_s[0]) begin
      state_d = m0_lock ? ST_OWN0 : ST_IDLE;
    end else if (gnt_s[1]) begin
      state_d = m1_lock ? ST_OWN1 : ST_IDLE;
    end else begin
      case (state_q)
        ST_OWN0: state_d = m0_lock ? ST_OWN0 : ST_IDLE;
        ST_OWN1: state_d = m1_lock ? ST_OWN1 : ST_IDLE;
        ST_IDLE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: grant vector, masked to the owner while a lock is held.
  always_comb begin
    gnt_s = 2'b00;
    if (rst) begin
      gnt_s = 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: gnt_s = pick_s;
        ST_OWN0: gnt_s = {1'b0, m0_req};
        ST_OWN1: gnt_s = {m1_req, 1'b0};
        default: gnt_s = 2'b00;
      endcase
    end
  end

  // Steer the granted requester onto the RAM; out-of-range writes never reach it.
  always_comb begin
    any_gnt_s   = |gnt_s;
    sel_s       = gnt_s[1];
    sel_addr_s  = sel_s ? m1_address : m0_address;
    sel_wdata_s = sel_s ? m1_wdata : m0_wdata;
    sel_enw_s   = sel_s ? m1_enw : m0_enw;
    sel_oor_s   = (sel_addr_s >= DEPTH_W);
    m0_gnt      = gnt_s[0];
    m1_gnt      = gnt_s[1];
    if (any_gnt_s) begin
      ram_enw     = sel_enw_s & ~sel_oor_s;
      ram_address = sel_addr_s;
      ram_wdata   = sel_wdata_s;
    end else begin
      ram_enw     = 1'b0;
      ram_address = {WIDTH{1'b0}};
      ram_wdata   = {WIDTH{1'b0}};
    end
  end

  // Next values for the round-robin pointer and the one-deep response pipe.
  always_comb begin
    if (gnt_s[0]) begin
      ptr_d = 1'b0;
    end else if (gnt_s[1]) begin
      ptr_d = 1'b1;
    end else begin
      ptr_d = ptr_q;
    end
    rsp_rd_d  = any_gnt_s & ~sel_enw_s;
    rsp_oor_d = any_gnt_s & sel_oor_s;
    rsp_idx_d = sel_s;
  end

  // Pointer and response pipeline registers; reset drops any in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= 1'b1;
      rsp_rd_q  <= 1'b0;
      rsp_oor_q <= 1'b0;
      rsp_idx_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      rsp_rd_q  <= rsp_rd_d;
      rsp_oor_q <= rsp_oor_d;
      rsp_idx_q <= rsp_idx_d;
    end
  end

  // Route the response to the requester that issued it; rdata is zero unless valid.
  always_comb begin
    rsp_oh_s  = idx_onehot(rsp_idx_q);
    m0_rvalid = rsp_rd_q & rsp_oh_s[0];
    m1_rvalid = rsp_rd_q & rsp_oh_s[1];
    m0_err    = rsp_oor_q & rsp_oh_s[0];
    m1_err    = rsp_oor_q & rsp_oh_s[1];
    if (m0_rvalid && !rsp_oor_q) begin
      m0_rdata = ram_rdata;
    end else begin
      m0_rdata = {WIDTH{1'b0}};
    end
    if (m1_rvalid && !rsp_oor_q) begin
      m1_rdata = ram_rdata;
    end else begin
      m1_rdata = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_ram_arbiter;

  localparam logic [31:0] DEPTH = 32'd100000;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_lock, m0_enw, m1_req, m1_lock, m1_enw;
  logic [31:0] m0_address, m0_wdata, m1_address, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_enw;
  logic [31:0] ram_address, ram_wdata;
  logic [31:0] ram_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.WIDTH(32), .DEPTH(100_000)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_enw(m0_enw),
    .m0_address(m0_address), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_enw(m1_enw),
    .m1_address(m1_address), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_enw(ram_enw), .ram_address(ram_address), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Power-up RAM contents; word 5 holds the well-known pattern.
  function automatic logic [31:0] ram_init(input logic [31:0] a);
    if (a == 32'd5) return 32'hDEADBEEF;
    return (a * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  // Storage slot: addresses 0..15 directly, everything else shares slot 16.
  function automatic int slot(input logic [31:0] a);
    return (a < 32'd16) ? int'(a) : 16;
  endfunction

  // Environment RAM: read data one cycle after the address.
  logic [31:0] env_mem [0:16];
  bit   [16:0] env_wr;
  always @(posedge clk) begin
    ram_rdata <= env_wr[slot(ram_address)] ? env_mem[slot(ram_address)] : ram_init(ram_address);
    if (ram_enw) begin
      env_mem[slot(ram_address)] <= ram_wdata;
      env_wr[slot(ram_address)]  <= 1'b1;
    end
  end

  // Behavioural model and per-cycle comparison.
  logic [31:0] mdl_mem [0:16];
  bit   [16:0] mdl_wr;
  initial begin
    int owner, last, g;
    bit p_valid, p_rd, p_oor;
    int p_idx;
    logic [31:0] p_data;
    bit r[2], lk[2], we[2];
    logic [31:0] ad[2], wd[2];
    logic [1:0] eg, ev, ee;
    logic [31:0] ea, ew, erd0, erd1;
    bit een;
    owner = -1; last = 1; p_valid = 1'b0; p_rd = 1'b0; p_oor = 1'b0; p_idx = 0; p_data = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        chk("rst_err", 32'({m1_err, m0_err}), 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        chk("rst_ram", 32'(ram_enw) | ram_address | ram_wdata, 32'd0);
        owner = -1; last = 1; p_valid = 1'b0;
      end else begin
        r[0] = m0_req; lk[0] = m0_lock; we[0] = m0_enw; ad[0] = m0_address; wd[0] = m0_wdata;
        r[1] = m1_req; lk[1] = m1_lock; we[1] = m1_enw; ad[1] = m1_address; wd[1] = m1_wdata;
        if (owner < 0) begin
          if (r[0] && r[1]) g = (last == 1) ? 0 : 1;
          else if (r[0]) g = 0;
          else if (r[1]) g = 1;
          else g = -1;
        end else begin
          g = r[owner] ? owner : -1;
        end
        eg = 2'b00; ea = 32'd0; ew = 32'd0; een = 1'b0;
        if (g >= 0) begin
          eg[g] = 1'b1; ea = ad[g]; ew = wd[g]; een = we[g] && (ad[g] < DEPTH);
        end
        ev = 2'b00; ee = 2'b00; erd0 = 32'd0; erd1 = 32'd0;
        if (p_valid && p_rd) ev[p_idx] = 1'b1;
        if (p_valid && p_oor) ee[p_idx] = 1'b1;
        if (ev[0] && !p_oor) erd0 = p_data;
        if (ev[1] && !p_oor) erd1 = p_data;
        chk("gnt", 32'({m1_gnt, m0_gnt}), 32'(eg));
        chk("ram_enw", 32'(ram_enw), 32'(een));
        chk("ram_address", ram_address, ea);
        chk("ram_wdata", ram_wdata, ew);
        chk("rvalid", 32'({m1_rvalid, m0_rvalid}), 32'(ev));
        chk("err", 32'({m1_err, m0_err}), 32'(ee));
        chk("m0_rdata", m0_rdata, erd0);
        chk("m1_rdata", m1_rdata, erd1);
        if (g >= 0) begin
          last = g;
          owner = lk[g] ? g : -1;
          p_valid = 1'b1; p_idx = g; p_rd = !we[g]; p_oor = (ad[g] >= DEPTH);
          p_data = mdl_wr[slot(ad[g])] ? mdl_mem[slot(ad[g])] : ram_init(ad[g]);
          if (we[g] && !p_oor) begin
            mdl_mem[slot(ad[g])] = wd[g];
            mdl_wr[slot(ad[g])]  = 1'b1;
          end
        end else begin
          p_valid = 1'b0;
          if (owner >= 0 && !lk[owner]) owner = -1;
        end
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic settle;
    @(negedge clk); #1;
  endtask

  task automatic drv(input int n, input bit rq, input bit lk, input bit we,
                     input logic [31:0] a, input logic [31:0] d);
    if (n == 0) begin
      m0_req = rq; m0_lock = lk; m0_enw = we; m0_address = a; m0_wdata = d;
    end else begin
      m1_req = rq; m1_lock = lk; m1_enw = we; m1_address = a; m1_wdata = d;
    end
  endtask

  task automatic idle_all;
    drv(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drv(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset;
    rst = 1'b1; idle_all(); settle(); next_cycle(); rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      7:       return 32'd99999;
      8:       return 32'd100000;
      9:       return 32'hFFFFFFFF;
      default: return 32'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    idle_all();
    // Reset holds everything quiet even with both requests high.
    m0_req = 1'b1; m1_req = 1'b1;
    settle();
    chk("reset_gnt_lit", 32'({m1_gnt, m0_gnt}), 32'd0);
    chk("reset_addr_lit", ram_address, 32'd0);
    next_cycle(); next_cycle();
    idle_all(); rst = 1'b0;

    // Single read of word 5.
    drv(0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
    settle();
    chk("rd5_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("rd5_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rd5_ram_address", ram_address, 32'd5);
    next_cycle(); idle_all(); settle();
    chk("rd5_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("rd5_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd5_m1_quiet", 32'({m1_rvalid, m1_err}) | m1_rdata, 32'd0);
    next_cycle();

    // Tie alternates starting with m0.
    do_reset();
    drv(0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
    drv(1, 1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rr_alternate", 32'({m1_gnt, m0_gnt}), (i % 2 == 0) ? 32'd1 : 32'd2);
      next_cycle();
    end
    idle_all();

    // m1 locked write burst while m0 keeps requesting.
    do_reset();
    drv(0, 1'b1, 1'b0, 1'b1, 32'd8, 32'h11);
    settle(); chk("pre_burst_m0_gnt", 32'(m0_gnt), 32'd1); next_cycle();
    for (int i = 0; i < 3; i++) begin
      drv(0, 1'b1, 1'b0, 1'b0, 32'd3, 32'd0);
      drv(1, 1'b1, 1'b1, 1'b1, 32'(i), 32'hA0 + 32'(i));
      settle();
      chk("burst_m0_blocked", 32'(m0_gnt), 32'd0);
      chk("burst_m1_gnt", 32'(m1_gnt), 32'd1);
      next_cycle();
    end
    drv(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    settle(); chk("unlock_cycle_gnt", 32'({m1_gnt, m0_gnt}), 32'd0); next_cycle();
    settle(); chk("after_unlock_m0_gnt", 32'(m0_gnt), 32'd1); next_cycle();
    idle_all();

    // Out-of-range write then read.
    drv(0, 1'b1, 1'b0, 1'b1, 32'd100000, 32'h1234);
    settle();
    chk("oor_wr_gnt", 32'(m0_gnt), 32'd1);
    chk("oor_wr_enw", 32'(ram_enw), 32'd0);
    next_cycle(); drv(0, 1'b1, 1'b0, 1'b0, 32'd100000, 32'd0); settle();
    chk("oor_rd_enw", 32'(ram_enw), 32'd0);
    chk("oor_wr_err", 32'(m0_err), 32'd1);
    chk("oor_wr_no_rvalid", 32'(m0_rvalid), 32'd0);
    next_cycle(); idle_all(); settle();
    chk("oor_rd_err", 32'(m0_err), 32'd1);
    chk("oor_rd_rvalid", 32'(m0_rvalid), 32'd1);
    chk("oor_rd_rdata", m0_rdata, 32'd0);
    next_cycle();

    // Reset with a read in flight.
    do_reset();
    drv(0, 1'b1, 1'b0, 1'b0, 32'd4, 32'd0);
    settle(); chk("inflight_gnt", 32'(m0_gnt), 32'd1);
    next_cycle(); idle_all(); rst = 1'b1;
    settle(); chk("inflight_rst_rvalid", 32'(m0_rvalid), 32'd0);
    next_cycle(); rst = 1'b0;
    settle(); chk("post_rst_rvalid_a", 32'(m0_rvalid), 32'd0); next_cycle();
    settle(); chk("post_rst_rvalid_b", 32'(m0_rvalid), 32'd0); next_cycle();
    drv(0, 1'b1, 1'b0, 1'b0, 32'd6, 32'd0);
    drv(1, 1'b1, 1'b0, 1'b0, 32'd6, 32'd0);
    settle(); chk("post_rst_ptr_tie", 32'({m1_gnt, m0_gnt}), 32'd1);
    next_cycle(); idle_all();
    settle(); next_cycle();

    // Responses follow their own requester across back-to-back grants.
    drv(1, 1'b1, 1'b0, 1'b0, 32'd7, 32'd0);
    settle(); chk("b2b_m1_gnt", 32'(m1_gnt), 32'd1);
    next_cycle(); idle_all(); drv(0, 1'b1, 1'b0, 1'b0, 32'd9, 32'd0);
    settle();
    chk("b2b_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("b2b_m1_rvalid", 32'(m1_rvalid), 32'd1);
    chk("b2b_m1_rdata", m1_rdata, 32'h5D5D0707);
    chk("b2b_m0_not_yet", 32'(m0_rvalid), 32'd0);
    next_cycle(); idle_all(); settle();
    chk("b2b_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("b2b_m0_rdata", m0_rdata, 32'h53530909);
    chk("b2b_m1_done", 32'(m1_rvalid), 32'd0);
    next_cycle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 2; k++) begin
        drv(k, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, rand_addr(), $urandom);
      end
      settle();
      next_cycle();
    end
    rst = 1'b0;
    idle_all();
    next_cycle(); next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
